// File: rtl/tape_transport.sv
`default_nettype none
// ============================================================================
// Module      : tape_transport
// Description : Tape motor model driven by one-hot P/R/F commands. It covers
//               spin-up and brake delays, a mode-dependent step prescaler and
//               a saturating position counter, and it raises BOT/EOT flags and
//               a Stop pulse at the tape ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_transport #(
  parameter int POS_W     = 16,
  parameter int TAPE_LEN  = 9000,
  parameter int PLAY_DIV  = 8,
  parameter int FAST_DIV  = 2,
  parameter int ACCEL_CYC = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             P,
  input  logic             R,
  input  logic             F,
  output logic [POS_W-1:0] Pos,
  output logic             BOT,
  output logic             EOT,
  output logic             Moving,
  output logic             Tick,
  output logic             Stop,
  output logic             Err
);

  localparam int MAX_DIV = (PLAY_DIV > FAST_DIV) ? PLAY_DIV : FAST_DIV;
  localparam int DIV_W   = $clog2(MAX_DIV + 1);
  localparam int RAMP_W  = $clog2(ACCEL_CYC + 1);

  localparam logic [POS_W-1:0]  END_POS    = POS_W'(TAPE_LEN);
  localparam logic [RAMP_W-1:0] RAMP_INIT  = RAMP_W'(ACCEL_CYC - 1);
  localparam logic [DIV_W-1:0]  PLAY_DIVM1 = DIV_W'(PLAY_DIV - 1);
  localparam logic [DIV_W-1:0]  FAST_DIVM1 = DIV_W'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPINUP = 2'd1,
    S_RUN    = 2'd2,
    S_BRAKE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cmd_q, cmd_d;       // latched one-hot {P,R,F}
  logic               fwd_q, fwd_d;
  logic [DIV_W-1:0]   divm1_q, divm1_d;
  logic [RAMP_W-1:0]  ramp_q, ramp_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               bot_q, eot_q, moving_q, tick_q, stop_q, err_q;
  logic               tick_d, stop_d, err_d;

  logic [2:0]         cmd_in;
  logic               multi, valid, in_fwd, blocked, same_cmd;
  logic [DIV_W-1:0]   in_divm1;

  // Decode the raw command inputs; a conflicting combination counts as no command.
  always_comb begin
    cmd_in   = {P, R, F};
    multi    = (P & R) | (P & F) | (R & F);
    valid    = (P | R | F) & ~multi;
    in_fwd   = P | F;
    in_divm1 = P ? PLAY_DIVM1 : FAST_DIVM1;
    blocked  = valid & (in_fwd ? eot_q : bot_q);
    same_cmd = valid & (cmd_in == cmd_q);
  end

  // Next-state logic for the motor FSM, prescaler and position counter.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    fwd_d   = fwd_q;
    divm1_d = divm1_q;
    ramp_d  = ramp_q;
    presc_d = presc_q;
    pos_d   = pos_q;
    tick_d  = 1'b0;
    stop_d  = 1'b0;
    err_d   = err_q | multi;
    case (state_q)
      S_IDLE: begin
        if (blocked) begin
          stop_d = 1'b1;
        end else if (valid) begin
          state_d = S_SPINUP;
          cmd_d   = cmd_in;
          fwd_d   = in_fwd;
          divm1_d = in_divm1;
          ramp_d  = RAMP_INIT;
        end
      end
      S_SPINUP: begin
        if (!same_cmd) begin
          state_d = S_BRAKE;
          ramp_d  = RAMP_INIT;
        end else if (ramp_q == '0) begin
          state_d = S_RUN;
          presc_d = '0;
        end else begin
          ramp_d = ramp_q - 1'b1;
        end
      end
      S_RUN: begin
        if (!same_cmd) begin
          state_d = S_BRAKE;
          ramp_d  = RAMP_INIT;
        end else if (presc_q == divm1_q) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (fwd_q) begin
            if (pos_q != END_POS) pos_d = pos_q + 1'b1;
          end else begin
            if (pos_q != '0) pos_d = pos_q - 1'b1;
          end
          // Reaching a tape end ends the run immediately.
          if ((fwd_q && pos_d == END_POS) || (!fwd_q && pos_d == '0)) begin
            stop_d  = 1'b1;
            state_d = S_BRAKE;
            ramp_d  = RAMP_INIT;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_BRAKE: begin
        if (ramp_q == '0) state_d = S_IDLE;
        else              ramp_d  = ramp_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset overrides every other event.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      fwd_q    <= 1'b0;
      divm1_q  <= '0;
      ramp_q   <= '0;
      presc_q  <= '0;
      pos_q    <= '0;
      bot_q    <= 1'b1;
      eot_q    <= 1'b0;
      moving_q <= 1'b0;
      tick_q   <= 1'b0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      fwd_q    <= fwd_d;
      divm1_q  <= divm1_d;
      ramp_q   <= ramp_d;
      presc_q  <= presc_d;
      pos_q    <= pos_d;
      bot_q    <= (pos_d == '0);
      eot_q    <= (pos_d == END_POS);
      moving_q <= (state_d != S_IDLE);
      tick_q   <= tick_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
    end
  end

  assign Pos    = pos_q;
  assign BOT    = bot_q;
  assign EOT    = eot_q;
  assign Moving = moving_q;
  assign Tick   = tick_q;
  assign Stop   = stop_q;
  assign Err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tape_transport.sv
`default_nettype none
// ============================================================================
// Module      : tb_tape_transport
// Description : Directed vector bench for tape_transport (TAPE_LEN=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_transport;

  logic        Clk = 1'b0;
  logic        Rst, P, R, F;
  logic [15:0] Pos;
  logic        BOT, EOT, Moving, Tick, Stop, Err;

  int n_tests = 0;
  int n_fail  = 0;

  tape_transport #(
    .POS_W(16), .TAPE_LEN(20), .PLAY_DIV(8), .FAST_DIV(2), .ACCEL_CYC(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .P(P), .R(R), .F(F),
    .Pos(Pos), .BOT(BOT), .EOT(EOT), .Moving(Moving),
    .Tick(Tick), .Stop(Stop), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic rst, p, r, f;
    int   n;
    int   pos;
    logic bot, eot, mv, tk, st, er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, p, r, f, input int n, input int pos,
                     input logic bot, eot, mv, tk, st, er);
    vec_t v;
    v.rst = rst; v.p = p; v.r = r; v.f = f; v.n = n; v.pos = pos;
    v.bot = bot; v.eot = eot; v.mv = mv; v.tk = tk; v.st = st; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Tick must never be high on two consecutive cycles.
  logic tick_prev = 1'b0;
  always @(negedge Clk) begin
    if (Tick) begin
      n_tests++;
      if (tick_prev) begin
        n_fail++;
        $display("FAIL tick_consecutive: got Tick=1 twice, expected single pulse");
      end
    end
    tick_prev = Tick;
  end

  initial begin
    int cnt;
    Rst = 1'b1; P = 1'b0; R = 1'b0; F = 1'b0;

    //   rst p r f   n   pos bot eot mv tk st er
    add(1, 0,0,0,   2,  0,  1,  0,  0, 0, 0, 0);  // reset state
    add(0, 1,0,0,   1,  0,  1,  0,  1, 0, 0, 0);  // edge 0: SPINUP
    add(0, 1,0,0,  11,  0,  1,  0,  1, 0, 0, 0);  // edge 11: not yet
    add(0, 1,0,0,   1,  1,  0,  0,  1, 1, 0, 0);  // edge 12: first step
    add(0, 1,0,0,   1,  1,  0,  0,  1, 0, 0, 0);  // edge 13
    add(0, 1,0,0,   7,  2,  0,  0,  1, 1, 0, 0);  // edge 20: second step
    add(0, 1,0,0,   8,  3,  0,  0,  1, 1, 0, 0);  // edge 28: Pos=3
    add(0, 0,0,1,   1,  3,  0,  0,  1, 0, 0, 0);  // P->F: brake, no step
    add(0, 0,0,1,   3,  3,  0,  0,  1, 0, 0, 0);  // still braking
    add(0, 0,0,1,   1,  3,  0,  0,  0, 0, 0, 0);  // IDLE after 4 brake cycles
    add(0, 0,0,1,   1,  3,  0,  0,  1, 0, 0, 0);  // fresh SPINUP
    add(0, 0,0,1,   5,  3,  0,  0,  1, 0, 0, 0);
    add(0, 0,0,1,   1,  4,  0,  0,  1, 1, 0, 0);  // first fast step
    add(0, 0,0,1,  31, 19,  0,  0,  1, 0, 0, 0);
    add(0, 0,0,1,   1, 20,  0,  1,  1, 1, 1, 0);  // EOT: Stop with Tick
    add(0, 0,0,1,   1, 20,  0,  1,  1, 0, 0, 0);
    add(0, 0,0,1,   2, 20,  0,  1,  1, 0, 0, 0);
    add(0, 0,0,1,   1, 20,  0,  1,  0, 0, 0, 0);  // IDLE, F still held
    add(0, 0,0,1,   1, 20,  0,  1,  0, 0, 1, 0);  // blocked: Stop
    add(0, 0,0,1,   1, 20,  0,  1,  0, 0, 1, 0);  // held: Stop repeats
    add(0, 0,0,0,   1, 20,  0,  1,  0, 0, 0, 0);
    add(0, 0,0,1,   1, 20,  0,  1,  0, 0, 1, 0);  // single F at EOT
    add(0, 0,0,0,   1, 20,  0,  1,  0, 0, 0, 0);
    add(0, 0,1,0,   1, 20,  0,  1,  1, 0, 0, 0);  // rewind SPINUP
    add(0, 0,1,0,   5, 20,  0,  1,  1, 0, 0, 0);
    add(0, 0,1,0,   1, 19,  0,  0,  1, 1, 0, 0);
    add(0, 0,1,0,  37,  1,  0,  0,  1, 0, 0, 0);
    add(0, 0,1,0,   1,  0,  1,  0,  1, 1, 1, 0);  // BOT: Stop with Tick
    add(0, 0,1,0,   3,  0,  1,  0,  1, 0, 0, 0);
    add(0, 0,1,0,   1,  0,  1,  0,  0, 0, 0, 0);
    add(0, 0,1,0,   1,  0,  1,  0,  0, 0, 1, 0);  // blocked at BOT
    add(0, 0,0,0,   1,  0,  1,  0,  0, 0, 0, 0);
    add(0, 1,1,0,   1,  0,  1,  0,  0, 0, 0, 1);  // P+R: Err
    add(0, 0,0,0,   2,  0,  1,  0,  0, 0, 0, 1);  // Err sticky
    add(0, 1,0,0,  68,  7,  0,  0,  1, 0, 0, 1);  // play to Pos=7
    add(1, 1,0,0,   1,  0,  1,  0,  0, 0, 0, 0);  // reset beats due step
    add(0, 0,0,0,   1,  0,  1,  0,  0, 0, 0, 0);

    foreach (vecs[i]) begin
      Rst = vecs[i].rst; P = vecs[i].p; R = vecs[i].r; F = vecs[i].f;
      repeat (vecs[i].n) @(posedge Clk);
      #1;
      n_tests++;
      if (Pos != 16'(vecs[i].pos) || BOT != vecs[i].bot || EOT != vecs[i].eot ||
          Moving != vecs[i].mv || Tick != vecs[i].tk || Stop != vecs[i].st ||
          Err != vecs[i].er) begin
        n_fail++;
        $display("FAIL row%0d: got pos=%0d bot=%0b eot=%0b mv=%0b tk=%0b st=%0b er=%0b expected pos=%0d bot=%0b eot=%0b mv=%0b tk=%0b st=%0b er=%0b",
                 i, Pos, BOT, EOT, Moving, Tick, Stop, Err,
                 vecs[i].pos, vecs[i].bot, vecs[i].eot, vecs[i].mv,
                 vecs[i].tk, vecs[i].st, vecs[i].er);
      end
    end

    // Full fast-forward run from reset: Stop lands on edge 44 (45th edge).
    Rst = 1'b1; P = 1'b0; R = 1'b0; F = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0; F = 1'b1;
    cnt = 0;
    do begin
      @(posedge Clk); #1;
      cnt++;
    end while (!Stop && cnt < 200);
    chk("ff_stop_edges", cnt, 45);
    chk("ff_stop_pos", int'(Pos), 20);
    chk("ff_stop_tick", int'(Tick), 1);
    cnt = 0;
    while (Moving && cnt < 20) begin
      @(posedge Clk); #1;
      cnt++;
    end
    chk("ff_brake_len", cnt, 4);
    chk("ff_final_eot", int'(EOT), 1);
    F = 1'b0;
    @(posedge Clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
